// File: rtl/slice_interleaver_pkg.sv
// rtl/slice_interleaver_pkg.sv - shared types and helpers for the slice interleaver
package slice_interleaver_pkg;

    localparam int FIFO_AF_MARGIN = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    function automatic int calc_gw(input int pixs, input int ncomp, input int bpc);
        return pixs * ncomp * bpc;
    endfunction

    // Valid mask of the last group in a chunk; a zero remainder means a full group.
    function automatic logic [7:0] last_mask(input logic [31:0] rem, input int pixs);
        int n;
        n = (rem == 32'd0) ? pixs : int'(rem);
        return 8'((9'd1 << n) - 9'd1);
    endfunction

endpackage

// File: rtl/slice_interleaver_pix_fifo.sv
// rtl/slice_interleaver_pix_fifo.sv - single-clock first-word-fall-through FIFO for one slice
module slice_pix_fifo #(
    parameter  int WIDTH     = 169,
    parameter  int DEPTH     = 64,
    parameter  int AF_MARGIN = 4,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty,
    output logic             o_almost_full,
    output logic [LW-1:0]    o_level
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [LW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_rd_ptr;
    logic             w_wr;
    logic             w_rd;

    assign w_rd = i_rd_en && !o_empty && !i_flush;
    // A pop in the same cycle frees the slot, so a write at full is still accepted.
    assign w_wr = i_wr_en && (!o_full || w_rd) && !i_flush;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + LW'(1);
            if (w_rd) r_rd_ptr <= r_rd_ptr + LW'(1);
        end
    end

    assign o_level       = r_wr_ptr - r_rd_ptr;
    assign o_empty       = (o_level == '0);
    assign o_full        = (o_level == LW'(DEPTH));
    assign o_almost_full = (o_level >= LW'(DEPTH - AF_MARGIN));
    assign o_rd_data     = r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/slice_interleaver.sv
// rtl/slice_interleaver.sv - round-robin slice-to-raster interleaver with ready/valid output
module slice_interleaver
    import slice_interleaver_pkg::*;
#(
    parameter  int NS              = 4,
    parameter  int PIXS            = 4,
    parameter  int NCOMP           = 3,
    parameter  int BPC             = 14,
    parameter  int FIFO_DEPTH      = 64,
    parameter  int MAX_SLICE_WIDTH = 2560,
    localparam int GW              = calc_gw(PIXS, NCOMP, BPC),
    localparam int SWW             = $clog2(MAX_SLICE_WIDTH + 1),
    localparam int SPLW            = $clog2(NS + 1)
) (
    input  logic               clk_core,
    input  logic               rst,
    input  logic               flush,
    input  logic [SPLW-1:0]    slices_per_line,
    input  logic [SWW-1:0]     slice_width,
    input  logic [15:0]        frame_height,
    input  logic [NS*GW-1:0]   in_data,
    input  logic [NS-1:0]      in_valid,
    input  logic [NS-1:0]      in_sof,
    output logic [NS-1:0]      fifo_almost_full,
    output logic [NS-1:0]      overflow,
    output logic [GW-1:0]      out_data,
    output logic [PIXS-1:0]    out_valid,
    output logic               out_sof,
    output logic               out_eol,
    output logic               out_eof,
    input  logic               out_ready
);

    localparam int SELW   = $clog2(NS);
    localparam int PIX_SH = $clog2(PIXS);
    localparam int LW     = $clog2(FIFO_DEPTH) + 1;

    logic [GW:0]      w_rd_data [NS];
    logic [LW-1:0]    w_level   [NS];
    logic [NS-1:0]    w_empty;
    logic [NS-1:0]    w_full;
    logic [NS-1:0]    w_pop;

    state_t           r_state, w_state_nxt;
    logic [SELW-1:0]  r_sel, w_sel_nxt, w_e_sel;
    logic [SWW-1:0]   r_grp, w_grp_nxt, w_e_grp;
    logic [15:0]      r_line, w_line_nxt, w_e_line;

    logic [GW-1:0]    r_out_data;
    logic [PIXS-1:0]  r_out_valid;
    logic             r_out_sof, r_out_eol, r_out_eof;
    logic [NS-1:0]    r_overflow;

    logic [GW:0]      w_head;
    logic             w_head_vld, w_head_sof, w_can_adv;
    logic             w_beat, w_discard, w_frame_start;
    logic             w_last_grp, w_last_sel, w_eol, w_eof;
    logic [SWW:0]     w_width_sum;
    logic [SWW-1:0]   w_groups;
    logic [PIXS-1:0]  w_last_mask, w_mask;

    for (genvar s = 0; s < NS; s++) begin : g_fifo
        slice_pix_fifo #(
            .WIDTH     (GW + 1),
            .DEPTH     (FIFO_DEPTH),
            .AF_MARGIN (FIFO_AF_MARGIN)
        ) u_fifo (
            .i_clk         (clk_core),
            .i_rst         (rst),
            .i_flush       (flush),
            .i_wr_en       (in_valid[s]),
            .i_wr_data     ({in_sof[s], in_data[s*GW +: GW]}),
            .i_rd_en       (w_pop[s]),
            .o_rd_data     (w_rd_data[s]),
            .o_full        (w_full[s]),
            .o_empty       (w_empty[s]),
            .o_almost_full (fifo_almost_full[s]),
            .o_level       (w_level[s])
        );

        a_level_bound: assert property (@(posedge clk_core) disable iff (rst)
            w_level[s] <= LW'(FIFO_DEPTH));
    end

    assign w_width_sum = {1'b0, slice_width} + (SWW + 1)'(PIXS - 1);
    assign w_groups    = SWW'(w_width_sum >> PIX_SH);
    assign w_last_mask = PIXS'(last_mask(32'(slice_width & SWW'(PIXS - 1)), PIXS));

    assign w_head     = w_rd_data[r_sel];
    assign w_head_sof = w_head[GW];
    assign w_head_vld = !w_empty[r_sel];
    assign w_can_adv  = (r_out_valid == '0) || out_ready;

    // Output decode: which head action happens and what the beat carries.
    always_comb begin
        w_discard     = 1'b0;
        w_beat        = 1'b0;
        w_frame_start = 1'b0;
        if (w_head_vld) begin
            if (r_state == ST_IDLE) begin
                if (!w_head_sof) begin
                    w_discard = 1'b1;
                end else if (w_can_adv) begin
                    w_beat        = 1'b1;
                    w_frame_start = 1'b1;
                end
            end else if (w_can_adv) begin
                w_beat = 1'b1;
                // Each slice's first group carries sof; only an unexpected one restarts the frame.
                w_frame_start = w_head_sof &&
                                ((r_sel == '0) || (r_grp != '0) || (r_line != '0));
            end
        end
        w_pop = '0;
        if (w_discard || w_beat) w_pop[r_sel] = 1'b1;

        w_e_sel    = w_frame_start ? '0 : r_sel;
        w_e_grp    = w_frame_start ? '0 : r_grp;
        w_e_line   = w_frame_start ? '0 : r_line;
        w_last_grp = (w_e_grp == w_groups - SWW'(1));
        w_last_sel = (SPLW'(w_e_sel) == slices_per_line - SPLW'(1));
        w_eol      = w_last_grp && w_last_sel;
        w_eof      = w_eol && (w_e_line == frame_height - 16'd1);
        w_mask     = w_last_grp ? w_last_mask : '1;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_grp_nxt   = r_grp;
        w_line_nxt  = r_line;
        if (w_beat) begin
            w_state_nxt = ST_STREAM;
            w_sel_nxt   = w_e_sel;
            w_grp_nxt   = w_last_grp ? '0 : w_e_grp + SWW'(1);
            w_line_nxt  = w_e_line;
            if (w_last_grp) begin
                w_sel_nxt = w_last_sel ? '0 : w_e_sel + SELW'(1);
                if (w_last_sel) w_line_nxt = w_e_line + 16'd1;
            end
            if (w_eof) begin
                w_state_nxt = ST_IDLE;
                w_line_nxt  = '0;
            end
        end
    end

    always_ff @(posedge clk_core or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_grp       <= '0;
            r_line      <= '0;
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_overflow  <= '0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_sel       <= '0;
            r_grp       <= '0;
            r_line      <= '0;
            r_out_data  <= '0;
            r_out_valid <= '0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_overflow  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_grp   <= w_grp_nxt;
            r_line  <= w_line_nxt;
            if (w_can_adv) begin
                r_out_valid <= w_beat ? w_mask : '0;
                r_out_sof   <= w_beat && w_frame_start;
                r_out_eol   <= w_beat && w_eol;
                r_out_eof   <= w_beat && w_eof;
                if (w_beat) r_out_data <= w_head[GW-1:0];
            end
            r_overflow <= r_overflow | (in_valid & w_full & ~w_pop);
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_eof   = r_out_eof;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_slice_interleaver.sv
// tb/tb_slice_interleaver.sv - directed self-checking bench for slice_interleaver
module tb_slice_interleaver;

    localparam int NS    = 2;
    localparam int PIXS  = 4;
    localparam int NCOMP = 3;
    localparam int BPC   = 14;
    localparam int DEPTH = 64;
    localparam int MSW   = 2560;
    localparam int GW    = PIXS * NCOMP * BPC;
    localparam int SWW   = $clog2(MSW + 1);
    localparam int SPLW  = $clog2(NS + 1);

    typedef logic [255:0] vec_t;

    logic              clk_core = 1'b0;
    logic              rst = 1'b1;
    logic              flush = 1'b0;
    logic [SPLW-1:0]   slices_per_line;
    logic [SWW-1:0]    slice_width;
    logic [15:0]       frame_height;
    logic [NS*GW-1:0]  in_data;
    logic [NS-1:0]     in_valid;
    logic [NS-1:0]     in_sof;
    logic [NS-1:0]     fifo_almost_full;
    logic [NS-1:0]     overflow;
    logic [GW-1:0]     out_data;
    logic [PIXS-1:0]   out_valid;
    logic              out_sof, out_eol, out_eof;
    logic              out_ready;

    int   errors = 0;
    int   checks = 0;
    vec_t beats[$];
    vec_t expq[$];
    logic       toggle = 1'b0;
    logic [3:0] ready_pat = 4'b1001;
    int         ph = 0;
    vec_t       prev_vec = '0;
    logic       prev_stall = 1'b0;

    slice_interleaver #(
        .NS (NS), .PIXS (PIXS), .NCOMP (NCOMP), .BPC (BPC),
        .FIFO_DEPTH (DEPTH), .MAX_SLICE_WIDTH (MSW)
    ) dut (
        .clk_core (clk_core), .rst (rst), .flush (flush),
        .slices_per_line (slices_per_line), .slice_width (slice_width),
        .frame_height (frame_height), .in_data (in_data), .in_valid (in_valid),
        .in_sof (in_sof), .fifo_almost_full (fifo_almost_full), .overflow (overflow),
        .out_data (out_data), .out_valid (out_valid), .out_sof (out_sof),
        .out_eol (out_eol), .out_eof (out_eof), .out_ready (out_ready)
    );

    always #5 clk_core = ~clk_core;

    task automatic check(input string tag, input vec_t obs, input vec_t exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic vec_t pack_beat(input logic sof, input logic eol, input logic eof,
                                       input logic [3:0] mask, input logic [GW-1:0] data);
        return vec_t'({sof, eol, eof, mask, data});
    endfunction

    function automatic logic [GW-1:0] tag(input int s, input int k);
        logic [GW-1:0] d;
        d = '0;
        d[15:0]       = 16'(s * 256 + k + 1);
        d[100 +: 8]   = 8'(s + 1);
        d[GW-1 -: 16] = 16'hC0DE ^ 16'(k);
        return d;
    endfunction

    always @(negedge clk_core) begin
        vec_t cur;
        cur = pack_beat(out_sof, out_eol, out_eof, out_valid, out_data);
        if (rst || flush) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) check("stall_hold", cur, prev_vec);
            if (out_valid != '0 && out_ready) beats.push_back(cur);
            prev_stall = (out_valid != '0) && !out_ready;
            prev_vec   = cur;
        end
    end

    task automatic cycle();
        @(posedge clk_core);
        #1;
        if (toggle) begin
            out_ready = ready_pat[ph];
            ph = (ph + 1) % 4;
        end
    endtask

    task automatic set_cfg(input int spl, input int w, input int fh);
        slices_per_line = SPLW'(spl);
        slice_width     = SWW'(w);
        frame_height    = 16'(fh);
    endtask

    task automatic write_frame(input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 2'b11;
            in_sof   = (k == 0) ? 2'b11 : 2'b00;
            in_data  = {tag(1, k), tag(0, k)};
            cycle();
        end
        in_valid = '0;
        in_sof   = '0;
    endtask

    task automatic build_exp(input int g, input logic [3:0] lm, input int fh);
        expq.delete();
        for (int ln = 0; ln < fh; ln++)
            for (int s = 0; s < NS; s++)
                for (int gi = 0; gi < g; gi++) begin
                    logic last;
                    last = (gi == g - 1);
                    expq.push_back(pack_beat(ln == 0 && s == 0 && gi == 0,
                                             last && s == NS - 1,
                                             last && s == NS - 1 && ln == fh - 1,
                                             last ? lm : 4'hF, tag(s, ln * g + gi)));
                end
    endtask

    task automatic collect_and_compare(input string name);
        int budget;
        budget = 400;
        while (beats.size() < expq.size() && budget > 0) begin
            cycle();
            budget--;
        end
        repeat (6) cycle();
        check({name, "_count"}, vec_t'(beats.size()), vec_t'(expq.size()));
        for (int i = 0; i < expq.size(); i++)
            check($sformatf("%s_beat%0d", name, i),
                  (i < beats.size()) ? beats[i] : '1, expq[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timeout");
    end

    initial begin
        out_ready = 1'b1;
        in_valid  = '0;
        in_sof    = '0;
        in_data   = '0;
        set_cfg(2, 10, 2);
        repeat (2) @(posedge clk_core);
        #1;
        check("reset_outputs", pack_beat(out_sof, out_eol, out_eof, out_valid, out_data), '0);
        check("reset_flags", vec_t'({overflow, fifo_almost_full}), '0);
        rst = 1'b0;
        cycle();

        // Width 10: three groups per chunk, last mask 0011.
        beats.delete();
        build_exp(3, 4'b0011, 2);
        write_frame(6);
        collect_and_compare("t1");

        beats.delete();
        ph = 0;
        toggle = 1'b1;
        build_exp(3, 4'b0011, 2);
        write_frame(6);
        collect_and_compare("t2");
        toggle = 1'b0;
        out_ready = 1'b1;

        beats.delete();
        set_cfg(2, 8, 2);
        build_exp(2, 4'hF, 2);
        write_frame(4);
        collect_and_compare("t3");

        // Leading non-sof groups on slice 0 must be dropped.
        beats.delete();
        set_cfg(2, 8, 1);
        for (int j = 0; j < 3; j++) begin
            in_valid = 2'b01;
            in_sof   = 2'b00;
            in_data  = {tag(1, 0), tag(0, 100 + j)};
            cycle();
        end
        in_valid = '0;
        build_exp(2, 4'hF, 1);
        write_frame(2);
        collect_and_compare("t4");

        // Slice 0 starved: fill slice 1 to full and beyond.
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 2'b10;
            in_sof   = 2'b00;
            in_data  = {tag(1, i), tag(0, 0)};
            cycle();
            if (i == DEPTH - 6) check("t5_af_lvl59", vec_t'(fifo_almost_full), vec_t'(2'b00));
            if (i == DEPTH - 5) check("t5_af_lvl60", vec_t'(fifo_almost_full), vec_t'(2'b10));
        end
        check("t5_full_no_ovf", vec_t'(overflow), '0);
        cycle();
        in_valid = '0;
        check("t5_ovf_set", vec_t'(overflow), vec_t'(2'b10));
        cycle();
        check("t5_ovf_sticky", vec_t'(overflow), vec_t'(2'b10));
        check("t5_no_output", vec_t'(out_valid), '0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        check("t5_flush_flags", vec_t'({overflow, fifo_almost_full}), '0);
        check("t5_flush_out", pack_beat(out_sof, out_eol, out_eof, out_valid, out_data), '0);

        // Asynchronous reset in the middle of a frame.
        beats.delete();
        set_cfg(2, 10, 2);
        write_frame(6);
        #2;
        check("t6_midframe", vec_t'(out_valid != '0), vec_t'(1'b1));
        rst = 1'b1;
        #1;
        check("t6_async_rst", pack_beat(out_sof, out_eol, out_eof, out_valid, out_data), '0);
        cycle();
        rst = 1'b0;
        beats.delete();
        for (int j = 0; j < 2; j++) begin
            in_valid = 2'b01;
            in_sof   = 2'b00;
            in_data  = {tag(1, 0), tag(0, 200 + j)};
            cycle();
        end
        in_valid = '0;
        repeat (10) cycle();
        check("t6_idle_nobeats", vec_t'(beats.size()), '0);

        set_cfg(2, 4, 1);
        in_valid = 2'b11;
        in_sof   = 2'b11;
        in_data  = {tag(1, 0), tag(0, 0)};
        cycle();
        in_valid = '0;
        in_sof   = '0;
        check("t6_lat_edge1", vec_t'(out_valid), '0);
        cycle();
        check("t6_lat_edge2", vec_t'(out_valid), vec_t'(4'hF));
        build_exp(1, 4'hF, 1);
        collect_and_compare("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/slice_interleaver.md
Name: slice_interleaver

Overview:
- Single-clock successor to the decoder's slice-to-raster output multiplexer, generalised in slice count, pixels per cycle, component count and bit depth.
- Buffers each slice's reconstructed pixel groups in a per-slice FIFO and interleaves them round-robin, one chunk (one slice-line) at a time, into a raster line stream with SOF/EOL/EOF markers.
- Adds behaviour the previous block lacked: ready/valid output backpressure, derived last-group valid mask, per-slice overflow flags, and a frame state machine.
- Sits between the per-slice decoder cores and the display output formatter.

Parameters:
- NS, 4, maximum number of slices (2..16).
- PIXS, 4, pixels per group/cycle (power of two: 1, 2, 4, 8).
- NCOMP, 3, components per pixel.
- BPC, 14, bits per component.
- FIFO_DEPTH, 64, groups per slice FIFO (power of two).
- MAX_SLICE_WIDTH, 2560, maximum slice width in pixels.
- Derived: GW = PIXS*NCOMP*BPC; SWW = $clog2(MAX_SLICE_WIDTH+1).

Ports:
- clk_core  in  1  block clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous abort; same effect as reset.
- slices_per_line  in  $clog2(NS+1)  active slices, 1..NS.
- slice_width  in  SWW  pixels per slice-line, >=1.
- frame_height  in  16  lines per frame, >=1.
- in_data  in  NS*GW  per-slice group; pixel p, component c of slice s at bits [((s*PIXS+p)*NCOMP+c)*BPC +: BPC].
- in_valid  in  NS  per-slice write strobe.
- in_sof  in  NS  first group of frame for that slice; qualified by in_valid.
- fifo_almost_full  out  NS  FIFO level >= FIFO_DEPTH-4.
- overflow  out  NS  sticky; write attempted while FIFO full.
- out_data  out  GW  interleaved group.
- out_valid  out  PIXS  per-pixel valid mask; nonzero means beat present.
- out_sof  out  1  first beat of frame.
- out_eol  out  1  last beat of a raster line.
- out_eof  out  1  last beat of frame.
- out_ready  in  1  downstream accept.

Behaviour:
- Reset values: all outputs 0; FIFOs empty; state IDLE; counters 0. flush: identical effect, applied synchronously.
- Chunk geometry:
  - G = ceil(slice_width/PIXS) groups per chunk.
  - rem = slice_width mod PIXS.
  - Last-group mask = (1<<rem)-1 if rem != 0, else all ones.
  - Every other group's mask is all ones.
- FIFO write:
  - Each FIFO stores {sof, data}.
  - A write with the FIFO full is dropped and sets overflow[s]; simultaneous read and write at full is allowed.
  - overflow clears only on rst or flush.
- Output handshake:
  - A beat transfers when out_valid != 0 and out_ready = 1.
  - While stalled, out_data, out_valid, out_sof, out_eol and out_eof are held stable.
  - The FIFO pops only when the output register is empty or transferring.
- State machine:
  - IDLE: discard FIFO0 head entries whose sof = 0 (pop them, no output). On a head with sof = 1, go to STREAM with sel = 0, grp = 0, line = 0.
  - STREAM: pop from FIFO[sel] when it is non-empty and the output is able to advance.
    - Each pop loads out_data and sets out_valid to that group's mask.
    - out_sof = 1 on the first beat of the frame.
    - grp increments per pop. At grp = G-1: grp wraps to 0 and sel advances.
    - When sel = slices_per_line-1, sel wraps to 0, out_eol = 1 on that beat, and line increments.
    - When line = frame_height-1 at that wrap, out_eof = 1 is also set and the state goes to IDLE.
  - A sof = 1 entry popped in STREAM at a position other than frame start is passed through with out_sof = 1, and sel, grp and line restart from that beat: new-frame resync.
- Empty FIFO[sel]: no pop, no beat (bubble). The block never skips to another slice.
- Latency: an input write to an empty FIFO (head slice) reaches out_valid 2 cycles later when out_ready = 1.
- Throughput: 1 group per cycle sustained.
- Config inputs are sampled and must be static while not in IDLE.

Decomposition:
- Package slice_interleaver_pkg: GW and mask-width helper functions, state encoding (IDLE, STREAM), FIFO_AF_MARGIN = 4.
- One sub-module: slice_pix_fifo, a single-clock FWFT FIFO of width GW+1 with full, empty, almost_full and level outputs, instantiated NS times.

Test Plan:
- NS=2, PIXS=4, slices_per_line=2, slice_width=10, frame_height=2, out_ready=1, both slices write 6 groups (3 per line) → 12 beats in order S0g0-2, S1g0-2, S0g0-2, S1g0-2. Masks 1111,1111,0011 per chunk; out_sof on beat 0; out_eol on beats 5 and 11; out_eof on beat 11 only.
- Same stimulus with out_ready toggling 1,0,0,1 → identical beat sequence; outputs held during stall cycles; no data loss.
- slice_width=8 → every mask 1111, G=2.
- FIFO0 preloaded with 3 groups with sof=0, then a sof group → first 3 discarded; out_sof on the 4th.
- Fill FIFO1 with FIFO_DEPTH groups while slice 0 is starved, then one more write → overflow[1]=1 and that write is dropped; fifo_almost_full[1] asserted at level 60. Flush → overflow clears, all outputs 0.
- Assert rst mid-frame for 1 cycle → outputs 0 immediately (asynchronous); after release, the block waits in IDLE for a new sof.
